// File: rtl/cam_ov7670_tx.sv
// cam_ov7670_tx
//
// Synthetic OV7670-style camera transmitter. Produces a free-running pixel
// clock (clk/2), VSYNC, HREF and an RGB565 byte stream (high byte first)
// filled with a selectable test pattern. Stands in for the physical sensor
// so the capture -> buffer -> display chain can run without hardware.
//
// Ports:
//   clk          in   system clock (camera xclk domain), only clock
//   rst          in   asynchronous active-low reset
//   enable       in   start / continue frame generation (sampled on byte edges)
//   pattern_sel  in   0 bars, 1 gradient, 2 solid, 3 checker
//   solid_color  in   RGB565 value used by the solid pattern
//   CAM_pclk     out  pixel clock = clk/2
//   CAM_vsync    out  frame sync, active high
//   CAM_href     out  line valid, active high
//   CAM_px_data  out  pixel byte, zero while CAM_href is low
//   frame_done   out  one-clk pulse on the byte edge that leaves VFRONT
//   frame_cnt    out  completed frames, wraps 255 -> 0
//   dbg_state    out  current FSM state (debug visibility)
//
// Timing contract: a "byte edge" is the clk edge on which CAM_pclk falls.
// Every register except the pclk divider only changes on byte edges, and all
// stream outputs are decoded from those registers, so CAM_vsync, CAM_href and
// CAM_px_data are stable across each CAM_pclk rising edge.
module cam_ov7670_tx #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic [2:0]  dbg_state
);

  localparam int L           = 2 * H_ACTIVE + H_BLANK;
  localparam int TOTAL_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW          = $clog2(L);
  localparam int VW          = $clog2(TOTAL_LINES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pclk_q;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          frame_done_q, frame_done_d;

  logic          byte_edge;
  logic          line_end;
  logic [VW-1:0] lines_m1;
  logic [31:0]   x_ext, y_ext, bar_idx;
  logic [15:0]   bar_px, pixel;
  logic          href;

  // pclk is high during the clk cycle that precedes a falling pclk edge.
  assign byte_edge = pclk_q;
  assign line_end  = (hcnt_q == HW'(L - 1));

  // vcnt counts lines within the current state; this is its last value.
  always_comb begin
    lines_m1 = '0;
    case (state_q)
      S_VSYNC:  lines_m1 = VW'(VSYNC_LINES - 1);
      S_VBACK:  lines_m1 = VW'(V_BACK - 1);
      S_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
      S_VFRONT: lines_m1 = VW'(V_FRONT - 1);
      default:  lines_m1 = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    pat_d        = pat_q;
    solid_d      = solid_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (byte_edge) begin
      if (state_q == S_IDLE) begin
        if (enable) begin
          state_d = S_VSYNC;
          hcnt_d  = '0;
          vcnt_d  = '0;
          pat_d   = pattern_sel;
          solid_d = solid_color;
        end
      end else if (!line_end) begin
        hcnt_d = hcnt_q + HW'(1);
      end else begin
        hcnt_d = '0;
        if (vcnt_q != lines_m1) begin
          vcnt_d = vcnt_q + VW'(1);
        end else begin
          vcnt_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            S_VFRONT: begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
              // Re-enabling before this edge chains frames with no IDLE gap.
              if (enable) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel;
                solid_d = solid_color;
              end else begin
                state_d = S_IDLE;
              end
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      pclk_q       <= 1'b0;
      pat_q        <= 2'd0;
      solid_q      <= 16'd0;
      frame_cnt_q  <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      pclk_q       <= ~pclk_q;
      pat_q        <= pat_d;
      solid_q      <= solid_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel generation; x is the pixel column (two bytes per pixel), y the
  // active line index.
  always_comb begin
    x_ext   = 32'(hcnt_q >> 1);
    y_ext   = 32'(vcnt_q);
    bar_idx = (x_ext << 3) / 32'(H_ACTIVE);
    case (bar_idx)
      32'd0:   bar_px = 16'hFFFF;
      32'd1:   bar_px = 16'hFFE0;
      32'd2:   bar_px = 16'h07FF;
      32'd3:   bar_px = 16'h07E0;
      32'd4:   bar_px = 16'hF81F;
      32'd5:   bar_px = 16'hF800;
      32'd6:   bar_px = 16'h001F;
      default: bar_px = 16'h0000;
    endcase
    case (pat_q)
      2'd0:    pixel = bar_px;
      2'd1:    pixel = 16'(((x_ext & 32'h1F) << 11) | ((y_ext & 32'h3F) << 5) | (x_ext & 32'h1F));
      2'd2:    pixel = solid_q;
      default: pixel = (x_ext[3] ^ y_ext[3] ^ frame_cnt_q[0]) ? 16'hFFFF : 16'h0000;
    endcase
    href = (state_q == S_ACTIVE) && (hcnt_q < HW'(2 * H_ACTIVE));
  end

  assign CAM_pclk    = pclk_q;
  assign CAM_vsync   = (state_q == S_VSYNC);
  assign CAM_href    = href;
  assign CAM_px_data = !href ? 8'h00 : (hcnt_q[0] ? pixel[7:0] : pixel[15:8]);
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cam_ov7670_tx.sv
module tb_cam_ov7670_tx;

  // Reduced geometry keeps each frame short; all timing rules scale with it.
  localparam int H_ACT     = 16;
  localparam int V_ACT     = 12;
  localparam int H_BLK     = 8;
  localparam int VS_LINES  = 2;
  localparam int VB_LINES  = 2;
  localparam int VF_LINES  = 2;
  localparam int LBYTES    = 2 * H_ACT + H_BLK;
  localparam int FRAME_CLK = (VS_LINES + VB_LINES + V_ACT + VF_LINES) * LBYTES * 2;

  localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data, frame_cnt;
  logic [2:0]  dbg_state;

  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish before cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  cam_ov7670_tx #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_BLANK(H_BLK),
    .VSYNC_LINES(VS_LINES), .V_BACK(VB_LINES), .V_FRONT(VF_LINES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel, straight from the pattern definitions.
  function automatic logic [15:0] model_pixel(input logic [1:0] sel, input logic [15:0] solid,
                                              input int x, input int y, input int fc);
    case (sel)
      2'd0:    return BAR_TAB[(x * 8) / H_ACT];
      2'd1:    return 16'(((x % 32) * 2048) + ((y % 64) * 32) + (x % 32));
      2'd2:    return solid;
      default: return ((((x / 8) + (y / 8) + fc) % 2) == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // ---------------- driver / frame checker ----------------
  // Checks one full frame. If VSYNC is already high on entry the frame began
  // at t_prev_end (back-to-back with the previous one). The pattern inputs
  // present at the frame start are the expected ones; nsel/nsolid are then
  // driven mid-frame and must not affect this frame. drop_line > 0 drops
  // enable when that HREF pulse starts.
  task automatic check_frame(input int fc, input logic [1:0] nsel, input logic [15:0] nsolid,
                             input int drop_line, input int t_prev_end,
                             output int t_rise, output int t_end);
    logic [1:0]  esel;
    logic [15:0] esolid, p;
    logic        b2b, prev_href;
    int          t0, guard, lines, bytes, zero_bad;
    logic [7:0]  e;
    b2b = (CAM_vsync === 1'b1);
    if (b2b) begin
      t0 = t_prev_end;
    end else begin
      guard = 0;
      while (CAM_vsync !== 1'b1 && guard < 3 * FRAME_CLK) begin
        @(negedge clk); guard++;
      end
      check("vsync_rise", CAM_vsync, 1'b1);
      t0 = cyc;
    end
    t_rise = t0;
    esel = pattern_sel;
    esolid = solid_color;
    pattern_sel = nsel;
    solid_color = nsolid;
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        p = model_pixel(esel, esolid, x, y, fc);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
    if (b2b) begin
      @(negedge clk);
      check("frame_done_width", frame_done, 1'b0);
    end
    guard = 0;
    while (CAM_vsync === 1'b1 && guard < FRAME_CLK) begin
      @(negedge clk); guard++;
    end
    check("vsync_width", 32'(cyc - t0), 32'(VS_LINES * LBYTES * 2));
    lines = 0; bytes = 0; zero_bad = 0; prev_href = 1'b0; guard = 0;
    while ((lines < V_ACT || CAM_href === 1'b1) && guard < FRAME_CLK) begin
      @(negedge clk); guard++;
      if (CAM_href === 1'b1 && !prev_href) begin
        lines++;
        bytes = 0;
        if (lines == 1) check("href_first_rise", 32'(cyc - t0), 32'((VS_LINES + VB_LINES) * LBYTES * 2));
        if (lines == drop_line) enable = 1'b0;
      end
      if (CAM_href !== 1'b1 && prev_href) check("href_bytes", 32'(bytes), 32'(2 * H_ACT));
      prev_href = (CAM_href === 1'b1);
      if (CAM_pclk === 1'b1) begin
        if (CAM_href === 1'b1) begin
          bytes++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("px_byte", CAM_px_data, e);
          end
        end else if (CAM_px_data !== 8'h00) begin
          zero_bad++;
        end
      end
    end
    check("href_lines", 32'(lines), 32'(V_ACT));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("blank_data_zero", 32'(zero_bad), 32'd0);
    exp_q.delete();
    guard = 0;
    while (frame_done !== 1'b1 && guard < FRAME_CLK) begin
      @(negedge clk); guard++;
    end
    check("frame_done", frame_done, 1'b1);
    check("frame_period", 32'(cyc - t0), 32'(FRAME_CLK));
    check("frame_cnt", frame_cnt, 8'((fc + 1) % 256));
    t_end = cyc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t_en, t_rise, t_end, t_rel, guard, quiet_bad, exp_fc;
    rst = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    solid_color = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_pclk", CAM_pclk, 1'b0);
    check("rst_vsync", CAM_vsync, 1'b0);
    check("rst_href", CAM_href, 1'b0);
    check("rst_px_data", CAM_px_data, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_cnt", frame_cnt, 8'h00);

    rst = 1'b1;
    @(negedge clk);
    check("pclk_first_rise", CAM_pclk, 1'b1);
    @(negedge clk);
    check("pclk_toggle", CAM_pclk, 1'b0);
    quiet_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0) quiet_bad++;
    end
    check("idle_before_enable", 32'(quiet_bad), 32'd0);

    // Frame 0 bars; then two checker frames; solid; bars; random.
    exp_fc = 0;
    enable = 1'b1;
    t_en = cyc;
    check_frame(exp_fc, 2'd3, 16'h0000, -1, 0, t_rise, t_end);
    check("vsync_latency", 32'((t_rise - t_en) <= 2 && (t_rise - t_en) >= 1), 32'd1);
    exp_fc++;
    check_frame(exp_fc, 2'd3, 16'h1234, -1, t_end, t_rise, t_end);
    exp_fc++;
    check_frame(exp_fc, 2'd2, 16'hF81F, -1, t_end, t_rise, t_end);
    exp_fc++;
    check_frame(exp_fc, 2'd0, 16'h5A5A, -1, t_end, t_rise, t_end);
    exp_fc++;
    check_frame(exp_fc, 2'($urandom_range(0, 3)), 16'($urandom), -1, t_end, t_rise, t_end);
    exp_fc++;
    for (int f = 0; f < 3; f++) begin
      check_frame(exp_fc, 2'($urandom_range(0, 3)), 16'($urandom),
                  (f == 2) ? V_ACT / 2 : -1, t_end, t_rise, t_end);
      exp_fc++;
    end

    // enable was dropped mid-frame: the generator must now stay quiet.
    @(negedge clk);
    check("last_frame_done_width", frame_done, 1'b0);
    quiet_bad = 0;
    repeat (2 * FRAME_CLK) begin
      @(negedge clk);
      if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 || frame_done !== 1'b0 || CAM_px_data !== 8'h00)
        quiet_bad++;
    end
    check("idle_after_drop", 32'(quiet_bad), 32'd0);
    check("frame_cnt_hold", frame_cnt, 8'(exp_fc));

    // Asynchronous reset in the middle of an active line.
    enable = 1'b1;
    guard = 0;
    while (CAM_href !== 1'b1 && guard < 2 * FRAME_CLK) begin
      @(negedge clk); guard++;
    end
    check("href_before_rst", CAM_href, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_pclk", CAM_pclk, 1'b0);
    check("arst_vsync", CAM_vsync, 1'b0);
    check("arst_href", CAM_href, 1'b0);
    check("arst_px_data", CAM_px_data, 8'h00);
    check("arst_frame_done", frame_done, 1'b0);
    check("arst_frame_cnt", frame_cnt, 8'h00);
    exp_fc = 0;
    @(negedge clk);
    rst = 1'b1;
    t_rel = cyc;
    guard = 0;
    while (CAM_vsync !== 1'b1 && guard < 10) begin
      @(negedge clk); guard++;
    end
    check("rst_vsync_latency", 32'(CAM_vsync === 1'b1 && (cyc - t_rel) <= 3), 32'd1);
    guard = 0;
    while (CAM_vsync === 1'b1 && guard < FRAME_CLK) begin
      @(negedge clk); guard++;
    end
    exp_fc++;
    check_frame(exp_fc, 2'($urandom_range(0, 3)), 16'($urandom), -1, 0, t_rise, t_end);
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
